alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal values 4..64).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_shamt  input  SHW  shift amount.
REQ-010 in_op  input  3  operation code.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_result  output  WIDTH  result.
REQ-014 out_ovf  output  1  signed overflow, meaningful for ADD/SUB only, 0 for all other ops.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The op codes SHALL be: 000 SRA (A>>>shamt), 001 SRL (A>>shamt), 010 SUB (A-B), 011 ADD (A+B), 100 SLL (A<<shamt), 101 AND, 110 OR, 111 SLT (signed A<B gives 1, else 0, zero-extended).
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; out_ovf = operand signs agree (B inverted for SUB) and result sign differs.
REQ-018 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready = (state==IDLE).
REQ-019 IDLE: on in_valid&&in_ready, latch in_a, in_b, in_shamt and in_op; inputs are ignored at all other times.
REQ-020 Non-shift op: result and ovf computed from the inputs in the accept cycle; go to DONE on the next edge (latency 1).
REQ-021 Shift op with shamt==0: go to DONE with result = A (latency 1).
REQ-022 Shift op with shamt>0: go to SHIFT; shift the working register one bit per cycle while a counter loaded with shamt decrements; go to DONE when the counter reaches 1 (latency 1+shamt).
REQ-023 SRA SHALL refill with the latched A[WIDTH-1]; SRL and SLL SHALL refill with 0.
REQ-024 DONE: out_valid=1; out_result and out_ovf held stable until out_valid&&out_ready, then go to IDLE on that edge.
REQ-025 No new request SHALL be accepted in the DONE handoff cycle; the next accept is earliest one cycle later.
REQ-026 out_valid SHALL be 0 in IDLE and SHIFT; out_result SHALL keep its last value outside DONE.
REQ-027 The illegal state encoding SHALL recover to IDLE.

Reset
REQ-028 reset SHALL immediately force state IDLE, out_valid 0, out_result 0, out_ovf 0, busy 0, the counter 0 and in_ready 1.
REQ-029 Reset in SHIFT or DONE SHALL abort the operation and discard its result; no out_valid pulse follows.

Structure
REQ-030 Package alu_pkg SHALL hold the op-code constants (OP_SRA..OP_SLT) and the FSM state encoding.
REQ-031 Sub-module alu_seq_comb SHALL compute the single-cycle ops (SUB, ADD, AND, OR, SLT, ovf) combinationally; alu_seq SHALL own the FSM, the shift register and the counter.

Verification (WIDTH=8)
REQ-032 SRA A=8'hF0 shamt=3 -> out_result 8'hFE, out_valid rises 4 cycles after accept.
REQ-033 SRL A=8'hF0 shamt=3 -> 8'h1E; SLL A=8'h81 shamt=1 -> 8'h02; SRA shamt=0 -> A after 1 cycle.
REQ-034 ADD 8'h7F+8'h01 -> 8'h80, ovf=1; SUB 8'h00-8'h01 -> 8'hFF, ovf=0; SLT A=8'hFF B=8'h01 -> 8'h01.
REQ-035 out_ready held low 5 cycles in DONE -> result stable, in_ready=0, a concurrent in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-036 reset asserted mid-SHIFT (SRA shamt=7, cycle 3) -> same-cycle in_ready=1, out_valid=0, and no result appears after release.
REQ-037 Back-to-back ADD requests with out_ready tied high -> one result every 2 cycles, none lost or duplicated.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes and FSM encoding for the sequential ALU.
// The shift ops are the only multi-cycle ones, so is_shift() selects the FSM path.
package alu_pkg;

  localparam logic [2:0] OP_SRA = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU ops (ADD/SUB/AND/OR/SLT) plus signed overflow.
// Shift op codes produce zero here; the sequencer handles them.
module alu_seq_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  assign lt   = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum;
        ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o = diff;
        // B's sign is effectively inverted for subtraction
        ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, lt};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish in 1 cycle, shifts take 1+shamt (one bit per cycle).
// Result is held in DONE until out_ready; no new request is taken until back in IDLE.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic             ovf_q,   ovf_d;

  logic [WIDTH-1:0] comb_res;
  logic             comb_ovf;
  logic [WIDTH-1:0] shift_nxt;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (in_op),
    .result_o (comb_res),
    .ovf_o    (comb_ovf)
  );

  // SRA keeps replicating the MSB, which is the latched A[WIDTH-1]
  always_comb begin
    case (op_q)
      OP_SRA:  shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_SLL:  shift_nxt = {work_q[WIDTH-2:0], 1'b0};
      default: shift_nxt = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ovf_d   = ovf_q;

    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          if (!is_shift(in_op)) begin
            res_d   = comb_res;
            ovf_d   = comb_ovf;
            state_d = ST_DONE;
          end else if (in_shamt == '0) begin
            res_d   = in_a;
            ovf_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            work_d  = in_a;
            cnt_d   = in_shamt;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = shift_nxt;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_d   = shift_nxt;
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SRA;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_result = res_q;
  assign out_ovf    = ovf_q;

endmodule
